// File: rtl/regbank_sequencer.sv
// Sequencer driving the 8-entry register bank: read setup/strobe/capture, ALU handoff, writeback strobe.
// Optional macro REGSEQ_R0_ZERO_EN hardwires register 0 to zero (reads yield 0, writes to r0 are dropped).
module regbank_sequencer #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int SETUP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic              req_rd1,
  input  logic              req_rd2,
  input  logic              req_wr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rb_addr1,
  output logic [ADDR_W-1:0] rb_addr2,
  output logic [ADDR_W-1:0] rb_addrdest,
  output logic [DATA_W-1:0] rb_datadest,
  output logic [2:0]        rb_control,
  output logic              rb_enable,
  input  logic [DATA_W-1:0] rb_data1,
  input  logic [DATA_W-1:0] rb_data2,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, RSETUP, RSTROBE, RCAPTURE, OP_WAIT, WB_WAIT, WSETUP, WSTROBE, WHOLD
  } state_t;

  localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYCLES - 1);

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic              rd1_q, rd2_q, wr_q;
  logic              req_ready_q, op_valid_q, wb_ready_q, rb_enable_q, busy_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, rb_datadest_q;
  logic [ADDR_W-1:0] rb_addr1_q, rb_addr2_q, rb_addrdest_q;
  logic [2:0]        rb_control_q;
  logic              src1_r0, src2_r0, dst_r0;

  always_comb begin
`ifdef REGSEQ_R0_ZERO_EN
    src1_r0 = (src1_q == '0);
    src2_r0 = (src2_q == '0);
    dst_r0  = (dst_q == '0);
`else
    src1_r0 = 1'b0;
    src2_r0 = 1'b0;
    dst_r0  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      dst_q         <= '0;
      rd1_q         <= 1'b0;
      rd2_q         <= 1'b0;
      wr_q          <= 1'b0;
      req_ready_q   <= 1'b0;
      op_valid_q    <= 1'b0;
      wb_ready_q    <= 1'b0;
      rb_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rb_datadest_q <= '0;
      rb_addr1_q    <= '0;
      rb_addr2_q    <= '0;
      rb_addrdest_q <= '0;
      rb_control_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (req_valid) begin
            src1_q      <= req_src1;
            src2_q      <= req_src2;
            dst_q       <= req_dst;
            rd1_q       <= req_rd1;
            rd2_q       <= req_rd2;
            wr_q        <= req_wr;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_rd1 || req_rd2) begin
              rb_addr1_q   <= req_src1;
              rb_addr2_q   <= req_src2;
              rb_control_q <= {1'b0, req_rd2, req_rd1};
              cnt_q        <= SETUP_LAST;
              state_q      <= RSETUP;
            end else begin
              op_a_q     <= '0;
              op_b_q     <= '0;
              op_valid_q <= 1'b1;
              state_q    <= OP_WAIT;
            end
          end
        end
        RSETUP: begin
          if (cnt_q == '0) begin
            rb_enable_q <= 1'b1;
            state_q     <= RSTROBE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RSTROBE: begin
          rb_enable_q <= 1'b0;
          state_q     <= RCAPTURE;
        end
        RCAPTURE: begin
          op_a_q     <= (rd1_q && !src1_r0) ? rb_data1 : '0;
          op_b_q     <= (rd2_q && !src2_r0) ? rb_data2 : '0;
          op_valid_q <= 1'b1;
          state_q    <= OP_WAIT;
        end
        OP_WAIT: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            if (wr_q) begin
              wb_ready_q <= 1'b1;
              state_q    <= WB_WAIT;
            end else begin
              rb_control_q <= '0;
              req_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        WB_WAIT: begin
          if (wb_valid) begin
            wb_ready_q <= 1'b0;
            // r0 writes complete the handshake but never reach the bank
            if (dst_r0) begin
              rb_control_q <= '0;
              req_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              rb_datadest_q <= wb_data;
              rb_addrdest_q <= dst_q;
              rb_control_q  <= 3'b100;
              cnt_q         <= SETUP_LAST;
              state_q       <= WSETUP;
            end
          end
        end
        WSETUP: begin
          if (cnt_q == '0) begin
            rb_enable_q <= 1'b1;
            state_q     <= WSTROBE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        WSTROBE: begin
          rb_enable_q <= 1'b0;
          state_q     <= WHOLD;
        end
        WHOLD: begin
          rb_control_q <= '0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign op_valid    = op_valid_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign wb_ready    = wb_ready_q;
  assign rb_addr1    = rb_addr1_q;
  assign rb_addr2    = rb_addr2_q;
  assign rb_addrdest = rb_addrdest_q;
  assign rb_datadest = rb_datadest_q;
  assign rb_control  = rb_control_q;
  assign rb_enable   = rb_enable_q;
  assign busy        = busy_q;

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
Initiator for the 8-entry register bank port set: addr1, addr2, addrdest, datadest, control[2:0] and the rising-edge enable strobe.
- Accepts register-access requests (two sources, one destination) from the decode stage.
- Sequences setup/strobe/capture toward the bank and delivers operands to the ALU.
- Collects the ALU writeback and strobes it into the bank.
- Sits between decode, the register bank and the ALU. It is the only agent driving the bank's control and enable.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register address width
SETUP_CYCLES, 1, cycles addresses/control are stable before the enable rising edge (legal range 1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_src1  in  ADDR_W  first source register
req_src2  in  ADDR_W  second source register
req_dst  in  ADDR_W  destination register
req_rd1  in  1  read src1
req_rd2  in  1  read src2
req_wr  in  1  write dst after ALU
op_valid  out  1  operands valid
op_ready  in  1  ALU takes operands
op_a  out  DATA_W  operand from src1
op_b  out  DATA_W  operand from src2
wb_valid  in  1  writeback data present
wb_ready  out  1  sequencer accepts writeback
wb_data  in  DATA_W  writeback value
rb_addr1  out  ADDR_W  bank read address 1
rb_addr2  out  ADDR_W  bank read address 2
rb_addrdest  out  ADDR_W  bank write address
rb_datadest  out  DATA_W  bank write data
rb_control  out  3  bit0 read1, bit1 read2, bit2 write
rb_enable  out  1  bank strobe; the bank acts on its rising edge
rb_data1  in  DATA_W  bank read data 1
rb_data2  in  DATA_W  bank read data 2
busy  out  1  state is not IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: req_ready=0 during the reset cycle, then 1. All of the following are 0: op_valid, op_a, op_b, wb_ready, all rb_* outputs, busy.
- States: IDLE, RSETUP, RSTROBE, RCAPTURE, OP_WAIT, WB_WAIT, WSETUP, WSTROBE, WHOLD.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the request fields.
  - If rd1|rd2, go to RSETUP; otherwise go to OP_WAIT with op_a=op_b=0.
- RSETUP:
  - Drive rb_addr1=src1, rb_addr2=src2, rb_control={0,rd2,rd1}, rb_enable=0.
  - Stay SETUP_CYCLES cycles (down-counter), then go to RSTROBE.
- RSTROBE: rb_enable=1 for exactly one cycle; addresses and control held. Go to RCAPTURE.
- RCAPTURE:
  - rb_enable=0.
  - op_a<=rb_data1 if rd1, else 0. op_b<=rb_data2 if rd2, else 0.
  - Go to OP_WAIT.
- OP_WAIT:
  - op_valid=1; op_a/op_b stable until op_valid&op_ready.
  - On handshake: if wr, go to WB_WAIT; else clear rb_control and go to IDLE.
- WB_WAIT:
  - wb_ready=1.
  - On wb_valid, latch wb_data into rb_datadest and drive rb_addrdest=dst.
  - Go to WSETUP.
- WSETUP: rb_control=3'b100, rb_enable=0, for SETUP_CYCLES cycles. Go to WSTROBE.
- WSTROBE: rb_enable=1 for one cycle. Go to WHOLD.
- WHOLD:
  - rb_enable=0; addrdest, datadest and control held one more cycle.
  - Then rb_control=0 and go to IDLE.
- Latency, SETUP_CYCLES=1:
  - Request accept to op_valid: 4 cycles.
  - wb handshake to return to IDLE: 4 cycles.
- Minimum request spacing: one request per full sequence. req_ready=0 outside IDLE; no new request is accepted while busy.
- rb_enable never stays high for two consecutive cycles. rb_addr*/rb_control never change during the cycle rb_enable is high or the cycle after it.
- Back-to-back: a read of the register written by the previous request sees the new value, because the write completes before IDLE.
- Reset mid-operation: the state returns to IDLE on the same edge and rb_enable drops to 0. A write aborted before WSTROBE is never strobed.
- wb_valid while not in WB_WAIT is ignored. op_ready while op_valid=0 is ignored.

Optional Feature:
REGSEQ_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero. A read of address 0 yields operand 0 regardless of rb_data.
  - A write with dst=0 consumes the wb handshake, then goes straight to IDLE with no WSETUP/WSTROBE; rb_enable stays 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then request src1=2, src2=5, rd1=rd2=1, wr=0, bank r2=8'h3C, r5=8'hA1 -> one rb_enable pulse at accept+2, op_valid at accept+4, op_a=8'h3C, op_b=8'hA1, back to IDLE after op_ready.
- Request rd1=1, src1=3, wr=1, dst=6, wb_data=8'h5A -> read strobe on addr 3, then write strobe with rb_control=3'b100, rb_addrdest=6, rb_datadest=8'h5A. A following read of r6 returns 8'h5A.
- SETUP_CYCLES=3, read request -> rb_enable rises exactly 3 cycles after addresses appear; rb_addr1 is stable through the strobe cycle and the cycle after.
- Assert rst during WSETUP with dst=4 -> no rb_enable pulse, r4 unchanged, all outputs 0, req_ready=1 the cycle after rst deasserts.
- With REGSEQ_R0_ZERO_EN, read r0 with bank r0=8'hFF -> op_a=0; write dst=0 -> no rb_enable pulse.
- Hold op_ready=0 for 5 cycles -> op_valid stays 1, op_a/op_b stable, req_ready=0, stray wb_valid ignored.
